// File: rtl/ccl_code_table_if.sv
// rtl/ccl_code_table_if.sv - header-byte write port and packed CCL result bus
interface ccl_code_table_if #(
  parameter int N_ENT = 4,
  parameter int CW    = 16
) ();
  logic                  winc;
  logic [7:0]            hdr_byte;
  logic                  CCL_rdy;
  logic [N_ENT*CW-1:0]   CCL_code_sq;
  logic [N_ENT*4-1:0]    CCL_count_sq;

  modport master (
    output winc, hdr_byte,
    input  CCL_rdy, CCL_code_sq, CCL_count_sq
  );

  modport slave (
    input  winc, hdr_byte,
    output CCL_rdy, CCL_code_sq, CCL_count_sq
  );
endinterface

// File: rtl/ccl_code_table.sv
// rtl/ccl_code_table.sv - Code-Count-List builder (canonical first-codes); CCL_SAT_EN selects saturation
module ccl_code_table #(
  parameter int N_ENT = 4,
  parameter int CW    = 16
) (
  input logic              clk,
  input logic              rst_n,
  ccl_code_table_if.slave  bus
);
  localparam int IW = (N_ENT > 1) ? $clog2(N_ENT) : 1;

  logic [IW-1:0]          idx;
  logic [CW-1:0]          code_run;
  logic [3:0]             cnt_prev;
  logic [3:0]             len_prev;
  logic [N_ENT*CW-1:0]    code_sh;
  logic [N_ENT*4-1:0]     cnt_sh;

  logic [3:0]             len_new;
  logic [3:0]             cnt_new;
  logic [3:0]             shamt;
  logic [CW-1:0]          c_calc;
  logic [CW-1:0]          c_new;
  logic [N_ENT*CW-1:0]    code_nxt;
  logic [N_ENT*4-1:0]     cnt_nxt;
  logic                   last;
`ifdef CCL_SAT_EN
  logic [CW:0]            sum;
  logic [2*CW-1:0]        wide;
`endif

  assign len_new = bus.hdr_byte[7:4];
  assign cnt_new = bus.hdr_byte[3:0];
  assign last    = (idx == IW'(N_ENT-1));

  // Next first-code from the running code, previous count and wrapped length delta
  always_comb begin
    shamt = len_new - len_prev;
`ifdef CCL_SAT_EN
    sum    = {1'b0, code_run} + {{(CW-3){1'b0}}, cnt_prev};
    wide   = {{(CW-1){1'b0}}, sum} << shamt;
    c_calc = (|wide[2*CW-1:CW]) ? {CW{1'b1}} : wide[CW-1:0];
`else
    c_calc = (code_run + {{(CW-4){1'b0}}, cnt_prev}) << shamt;
`endif
    c_new = (idx == '0) ? '0 : c_calc;
  end

  // Shadow lists with the incoming entry dropped into its slot (entry 0 in MSBs)
  always_comb begin
    code_nxt = code_sh;
    cnt_nxt  = cnt_sh;
    for (int k = 0; k < N_ENT; k++) begin
      if (idx == IW'(k)) begin
        code_nxt[(N_ENT-1-k)*CW +: CW] = c_new;
        cnt_nxt[(N_ENT-1-k)*4 +: 4]    = cnt_new;
      end
    end
  end

  // Per-byte state: entry index, recurrence history and shadow lists
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      code_run <= '0;
      cnt_prev <= '0;
      len_prev <= '0;
      code_sh  <= '0;
      cnt_sh   <= '0;
    end else if (bus.winc) begin
      idx      <= last ? '0 : idx + 1'b1;
      code_run <= c_new;
      cnt_prev <= cnt_new;
      len_prev <= len_new;
      code_sh  <= code_nxt;
      cnt_sh   <= cnt_nxt;
    end
  end

  // Published packet: loads on the last byte, ready drops on the next accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.CCL_rdy      <= 1'b0;
      bus.CCL_code_sq  <= '0;
      bus.CCL_count_sq <= '0;
    end else if (bus.winc) begin
      bus.CCL_rdy <= last;
      if (last) begin
        bus.CCL_code_sq  <= code_nxt;
        bus.CCL_count_sq <= cnt_nxt;
      end
    end
  end
endmodule

// File: tb/tb_ccl_code_table.sv
// tb/tb_ccl_code_table.sv - directed self-checking bench for ccl_code_table
module tb_ccl_code_table;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ccl_code_table_if #(.N_ENT(4), .CW(16)) bus ();

  ccl_code_table #(.N_ENT(4), .CW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] BASIC_CODE_PLAIN = 64'h0000_5000_500e_0130;
  localparam logic [63:0] BASIC_CODE_SAT   = 64'h0000_5000_500e_ffff;
  localparam logic [15:0] BASIC_CNT        = 16'hae50;
  localparam logic [63:0] ASC_CODE         = 64'h0000_0004_000a_001a;
  localparam logic [15:0] ASC_CNT          = 16'h2132;

`ifdef CCL_SAT_EN
  localparam logic [63:0] BASIC_CODE = BASIC_CODE_SAT;
`else
  localparam logic [63:0] BASIC_CODE = BASIC_CODE_PLAIN;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.winc     = 1'b1;
    bus.hdr_byte = b;
    @(posedge clk);
    #1;
    bus.winc     = 1'b0;
    bus.hdr_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.winc     = 1'b0;
    bus.hdr_byte = 8'h00;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rdy",   {63'd0, bus.CCL_rdy}, 64'd0);
    check("rst_code",  bus.CCL_code_sq, 64'd0);
    check("rst_count", {48'd0, bus.CCL_count_sq}, 64'd0);
    rst_n = 1'b1;
    idle(1);

    // basic packet
    push(8'hda);
    push(8'h8e);
    push(8'h85);
    check("basic_rdy_early", {63'd0, bus.CCL_rdy}, 64'd0);
    push(8'hc0);
    check("basic_rdy",   {63'd0, bus.CCL_rdy}, 64'd1);
    check("basic_count", {48'd0, bus.CCL_count_sq}, {48'd0, BASIC_CNT});
    check("basic_code",  bus.CCL_code_sq, BASIC_CODE);
    idle(3);
    check("hold_rdy",   {63'd0, bus.CCL_rdy}, 64'd1);
    check("hold_code",  bus.CCL_code_sq, BASIC_CODE);
    check("hold_count", {48'd0, bus.CCL_count_sq}, {48'd0, BASIC_CNT});

    // ascending lengths; first byte drops ready, old outputs persist
    push(8'h12);
    check("asc_rdy_drop",   {63'd0, bus.CCL_rdy}, 64'd0);
    check("asc_code_keep",  bus.CCL_code_sq, BASIC_CODE);
    push(8'h21);
    push(8'h33);
    push(8'h42);
    check("asc_rdy",   {63'd0, bus.CCL_rdy}, 64'd1);
    check("asc_count", {48'd0, bus.CCL_count_sq}, {48'd0, ASC_CNT});
    check("asc_code",  bus.CCL_code_sq, ASC_CODE);

    // back-to-back: ready high exactly one cycle, then stalled packet
    push(8'h12);
    check("b2b_rdy_one", {63'd0, bus.CCL_rdy}, 64'd0);
    push(8'h21);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("stall_rdy", {63'd0, bus.CCL_rdy}, 64'd0);
    end
    push(8'h33);
    check("stall_rdy_b2", {63'd0, bus.CCL_rdy}, 64'd0);
    push(8'h42);
    check("stall_rdy",   {63'd0, bus.CCL_rdy}, 64'd1);
    check("stall_count", {48'd0, bus.CCL_count_sq}, {48'd0, ASC_CNT});
    check("stall_code",  bus.CCL_code_sq, ASC_CODE);
    push(8'h77);
    check("next_rdy_fall", {63'd0, bus.CCL_rdy}, 64'd0);
    check("next_code",     bus.CCL_code_sq, ASC_CODE);
    check("next_count",    {48'd0, bus.CCL_count_sq}, {48'd0, ASC_CNT});

    // reset mid-packet (asynchronous, between edges)
    push(8'h12);
    push(8'h21);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_code",  bus.CCL_code_sq, 64'd0);
    check("mid_rst_count", {48'd0, bus.CCL_count_sq}, 64'd0);
    #1;
    rst_n = 1'b1;
    idle(1);
    push(8'hda);
    push(8'h8e);
    push(8'h85);
    push(8'hc0);
    check("mid_rdy",   {63'd0, bus.CCL_rdy}, 64'd1);
    check("mid_count", {48'd0, bus.CCL_count_sq}, {48'd0, BASIC_CNT});
    check("mid_code",  bus.CCL_code_sq, BASIC_CODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
